// File: rtl/jttrack_pcm_prefetch.sv
// jttrack_pcm_prefetch: two-entry 32-bit line buffer between the PCM address
// generator and the SDRAM ROM arbiter PCM slot.
// Optional feature macro: JTTRACK_PCM_PREFETCH_EN adds a next-line prefetch
// after every demand fill. Without it, both lines are filled by demand misses only.
module jttrack_pcm_prefetch #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          pcm_cs,
  input  logic [AW-1:0] pcm_addr,
  output logic [7:0]    pcm_data,
  output logic          pcm_ok,
  output logic          rom_cs,
  output logic [AW-3:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok
);

  localparam int unsigned TW = AW - 2;

`ifdef JTTRACK_PCM_PREFETCH_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DEMAND, ST_PREFETCH} state_e;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_DEMAND} state_e;
`endif

  state_e        state_q, state_d;
  logic          rom_cs_q, rom_cs_d;
  logic [TW-1:0] rom_addr_q, rom_addr_d;
  logic          discard_q, discard_d;
  logic [TW-1:0] tag_q [2];
  logic [31:0]   data_q [2];
  logic [1:0]    valid_q;
  logic          lru_q;
  logic [AW-1:0] last_addr_q;
  logic [7:0]    pcm_data_q;
  logic          pcm_ok_q;

  logic [TW-1:0] req_tag;
  logic          hit0, hit1, hit, hit_idx, victim, ack, drop, start;
  logic [31:0]   hit_word;
  logic [7:0]    hit_byte;
  logic          fill_en, fill_idx, dem_fill;

  assign req_tag  = pcm_addr[AW-1:2];
  // Valid bits are treated as cleared in the very cycle downloading is seen.
  assign hit0     = pcm_cs & valid_q[0] & ~downloading & (tag_q[0] == req_tag);
  assign hit1     = pcm_cs & valid_q[1] & ~downloading & (tag_q[1] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_idx  = ~hit0;
  assign hit_word = hit0 ? data_q[0] : data_q[1];
  assign victim   = ~valid_q[0] ? 1'b0 : (~valid_q[1] ? 1'b1 : ~lru_q);
  assign ack      = rom_cs_q & rom_ok;
  assign drop     = discard_q | downloading;
  assign start    = pcm_cs & ~hit & ~downloading;

`ifdef JTTRACK_PCM_PREFETCH_EN
  logic          dem_idx_q, dem_idx_d;
  logic [TW-1:0] next_tag;
  logic          next_res;
  assign next_tag = rom_addr_q + TW'(1);
  assign next_res = valid_q[~victim] & (tag_q[~victim] == next_tag);
`endif

  // Byte lane select within the hitting line
  always_comb begin
    hit_byte = hit_word[7:0];
    case (pcm_addr[1:0])
      2'd1:    hit_byte = hit_word[15:8];
      2'd2:    hit_byte = hit_word[23:16];
      2'd3:    hit_byte = hit_word[31:24];
      default: hit_byte = hit_word[7:0];
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DEMAND;
      ST_DEMAND: if (ack) begin
`ifdef JTTRACK_PCM_PREFETCH_EN
        state_d = (~drop & ~next_res) ? ST_PREFETCH : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef JTTRACK_PCM_PREFETCH_EN
      ST_PREFETCH: if (ack || (!rom_cs_q && downloading)) state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: fetch request, line address, fill strobes, discard tracking
  always_comb begin
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    discard_d  = discard_q | (downloading & (state_q != ST_IDLE));
    fill_en    = 1'b0;
    fill_idx   = victim;
    dem_fill   = 1'b0;
`ifdef JTTRACK_PCM_PREFETCH_EN
    dem_idx_d  = dem_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (start) begin
          rom_cs_d   = 1'b1;
          rom_addr_d = req_tag;
        end
      end
      ST_DEMAND: if (ack) begin
        rom_cs_d  = 1'b0;
        discard_d = 1'b0;
        fill_en   = ~drop;
        dem_fill  = ~drop;
`ifdef JTTRACK_PCM_PREFETCH_EN
        dem_idx_d = victim;
`endif
      end
`ifdef JTTRACK_PCM_PREFETCH_EN
      ST_PREFETCH: begin
        fill_idx = ~dem_idx_q;
        if (ack) begin
          rom_cs_d  = 1'b0;
          discard_d = 1'b0;
          fill_en   = ~drop;
        end else if (!rom_cs_q) begin
          // First PREFETCH cycle keeps rom_cs low, giving the mandatory gap
          discard_d = 1'b0;
          if (!downloading) begin
            rom_cs_d   = 1'b1;
            rom_addr_d = next_tag;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Fetch control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      discard_q  <= 1'b0;
`ifdef JTTRACK_PCM_PREFETCH_EN
      dem_idx_q  <= 1'b0;
`endif
    end else begin
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      discard_q  <= discard_d;
`ifdef JTTRACK_PCM_PREFETCH_EN
      dem_idx_q  <= dem_idx_d;
`endif
    end
  end

  // Line entries and most-recently-used tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      lru_q     <= 1'b0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      if (downloading)  valid_q <= '0;
      else if (fill_en) valid_q[fill_idx] <= 1'b1;
      if (fill_en) begin
        tag_q[fill_idx]  <= rom_addr_q;
        data_q[fill_idx] <= rom_data;
      end
      if (dem_fill) lru_q <= victim;
      else if (hit) lru_q <= hit_idx;
    end
  end

  // Consumer output register: data on hit, ok only once the address is stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q <= '0;
      pcm_data_q  <= '0;
      pcm_ok_q    <= 1'b0;
    end else begin
      last_addr_q <= pcm_addr;
      if (hit) pcm_data_q <= hit_byte;
      pcm_ok_q    <= hit & (pcm_addr == last_addr_q);
    end
  end

  assign pcm_data = pcm_data_q;
  assign pcm_ok   = pcm_ok_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_jttrack_pcm_prefetch.sv
// Bench for jttrack_pcm_prefetch: ROM arbiter model, scoreboard of expected
// bytes, fetch log. Expectations adapt to JTTRACK_PCM_PREFETCH_EN.
module tb_jttrack_pcm_prefetch;

`ifdef JTTRACK_PCM_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic        clk, rst_n, downloading, pcm_cs;
  logic [15:0] pcm_addr;
  logic [7:0]  pcm_data;
  logic        pcm_ok, rom_cs, rom_ok;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;

  jttrack_pcm_prefetch #(.AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .pcm_cs(pcm_cs),
    .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  typedef struct { int unsigned addr; logic [7:0] data; } exp_t;
  exp_t exp_q[$];
  int   f_addr[$], f_cyc[$], f_held[$], f_gap[$], f_start[$];
  int   fbase;
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, lat = 0, rise_cyc = 0, drive_cyc = 0;

  function automatic logic [31:0] rom_word(input int unsigned line);
    if (line == 0) return 32'h44332211;
    return 32'((line * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  function automatic logic [7:0] rom_byte(input int unsigned a);
    logic [31:0] w;
    w = rom_word(a >> 2);
    return w[8*(a%4) +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Arbiter model: grants rom_ok after lat cycles of rom_cs, logs each fetch
  initial begin
    int cnt, low;
    cnt = 0; low = 100; rom_ok = 0; rom_data = 0;
    forever begin
      @(negedge clk);
      if (rom_cs) begin
        if (cnt == 0) f_start.push_back(cyc);
        if (cnt == lat) begin
          rom_ok = 1; rom_data = rom_word(int'(rom_addr));
          f_addr.push_back(int'(rom_addr)); f_cyc.push_back(cyc);
          f_held.push_back(cnt + 1); f_gap.push_back(low);
          cnt = 0; low = 0;
        end else begin
          rom_ok = 0; rom_data = $urandom; cnt++;
        end
      end else begin
        rom_ok = 0; rom_data = $urandom; cnt = 0; low++;
      end
    end
  end

  // Scoreboard monitor: each rising pcm_ok consumes one expected byte
  initial begin
    logic ok_prev;
    exp_t e;
    ok_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) ok_prev = 0;
      else begin
        if (pcm_ok && !ok_prev) begin
          rise_cyc = cyc;
          if (exp_q.size() == 0) check("sb_unexpected_ok", 32'(pcm_addr), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            check("ok_addr", 32'(pcm_addr), e.addr);
            check("pcm_data", 32'(pcm_data), 32'(e.data));
          end
        end
        ok_prev = pcm_ok;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst_n = 0; pcm_cs = 0; downloading = 0; pcm_addr = 0;
    repeat (2) @(posedge clk);
    #2;
    fbase = f_addr.size();
    rst_n = 1;
    @(posedge clk); #2;
  endtask

  function automatic int fcount();
    return f_addr.size() - fbase;
  endfunction

  task automatic drive_addr(input int unsigned a);
    exp_t e;
    @(posedge clk); #2;
    pcm_cs = 1; pcm_addr = 16'(a); drive_cyc = cyc;
    e.addr = a; e.data = rom_byte(a);
    exp_q.push_back(e);
  endtask

  task automatic wait_ok(input string tag, output int zeros);
    bit done;
    done = 0; zeros = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #2;
      if (!pcm_ok) zeros++;
      else if (zeros > 0) done = 1;
    end
    check(tag, 32'(done), 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_cs(input string tag);
    for (int i = 0; i < 20 && !rom_cs; i++) begin @(posedge clk); #2; end
    check(tag, 32'(rom_cs), 1);
  endtask

  task automatic read(input int unsigned a, output int zeros);
    drive_addr(a);
    wait_ok("read_ok", zeros);
  endtask

  initial begin
    int z;
    rst_n = 0; pcm_cs = 0; downloading = 0; pcm_addr = 0; fbase = 0;
    #1;
    check("rst_rom_cs", 32'(rom_cs), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_pcm_ok", 32'(pcm_ok), 0);
    check("rst_pcm_data", 32'(pcm_data), 0);

    // First read after reset, two-cycle arbiter
    lat = 2;
    do_reset();
    drive_addr(16'h0002);
    wait_ok("t1_ok", z);
    check("t1_cs_latency", 32'(f_start[fbase] - drive_cyc), 1);
    check("t1_rom_addr", 32'(f_addr[fbase]), 0);
    check("t1_ok_after_rok", 32'(rise_cyc - f_cyc[fbase]), 2);
    repeat (10) @(posedge clk);
    #2;
    check("t1_fetches", 32'(fcount()), 32'(1 + PF));
    if (fcount() > 1) check("t1_pf_addr", 32'(f_addr[fbase+1]), 1);

    // Sequential bytes 0..15, zero-wait arbiter
    lat = 0;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      read(a, z);
      if (a != 0 && ((a % 4) != 0 || (PF == 1 && (a % 8) == 4)))
        check($sformatf("seq_dip_%0d", a), 32'(z), 1);
    end
    repeat (6) @(posedge clk);
    #2;
    check("seq_fetches", 32'(fcount()), 4);
    for (int i = 0; i < 4 && i < fcount(); i++)
      check($sformatf("seq_line_%0d", i), 32'(f_addr[fbase+i]), 32'(i));

    // Line address wrap-around
    lat = 1;
    do_reset();
    read(16'hFFFC, z);
    read(16'h0001, z);
    repeat (6) @(posedge clk);
    #2;
    check("wrap_fetches", 32'(fcount()), 2);
    if (fcount() == 2) begin
      check("wrap_first", 32'(f_addr[fbase]), 32'h3FFF);
      check("wrap_second", 32'(f_addr[fbase+1]), 0);
    end

    // Miss arriving while the previous line fetch is still in flight
    lat = 3;
    do_reset();
    read(16'h0100, z);
    read(16'h0200, z);
    if (fcount() > PF + 1) begin
      check("mid_held", 32'(f_held[fbase+1]), 32'(lat + 1));
      check("mid_new_line", 32'(f_addr[fbase+PF+1]), 32'h80);
      check("mid_gap", 32'(f_gap[fbase+PF+1]), (PF == 1) ? 1 : 3);
    end else check("mid_fetch_count", 32'(fcount()), 32'(PF + 2));

    // Download pulse during a demand fetch
    lat = 3;
    do_reset();
    drive_addr(16'h0300);
    wait_cs("dl_cs");
    @(posedge clk); #2; downloading = 1;
    @(posedge clk); #2; downloading = 0;
    wait_ok("dl_ok", z);
    if (fcount() >= 2) begin
      check("dl_first", 32'(f_addr[fbase]), 32'hC0);
      check("dl_refetch", 32'(f_addr[fbase+1]), 32'hC0);
      check("dl_gap", 32'(f_gap[fbase+1]), 1);
      check("dl_ok_after_refetch", 32'(rise_cyc - f_cyc[fbase+1]), 2);
    end else check("dl_fetch_count", 32'(fcount()), 2);

    // Reset mid-demand
    lat = 4;
    do_reset();
    drive_addr(16'h0404);
    wait_cs("rst_cs");
    @(posedge clk); #2; rst_n = 0;
    #1;
    check("midrst_rom_cs", 32'(rom_cs), 0);
    check("midrst_pcm_ok", 32'(pcm_ok), 0);
    @(posedge clk); #2; rst_n = 1;
    wait_ok("midrst_ok", z);
    if (fcount() > 0) check("midrst_line", 32'(f_addr[fbase]), 32'h101);

    repeat (4) @(posedge clk);
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
